// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for instruction_memory.
// Packs a big-endian byte stream into 32-bit words, writes them to
// consecutive addresses, verifies a trailing 8-bit checksum and only then
// releases the core from reset.
module imem_loader #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_data,
    output logic              imem_wren,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_CHK   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    // Modulo-256 checksum accumulation; the image is good when the
    // running sum plus the trailing byte wraps to zero.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        sum8 = a + b;
    endfunction

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_sum;
    logic [DATA_W-1:0] r_word;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [DATA_W-1:0] r_imem_data;
    logic              r_imem_wren;
    logic              r_core_rst_n;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic [2:0]        w_next;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_word;
    logic [DATA_W-1:0] w_word_next;
    logic [7:0]        w_sum_next;

    assign in_ready    = (r_state == ST_RECV) | (r_state == ST_CHK);
    assign w_accept    = in_valid & in_ready;
    assign w_start_ok  = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));
    assign w_last_word = (r_word_idx == (r_count - ADDR_ONE));
    // First byte of a word ends up in [31:24] after four shifts.
    assign w_word_next = {r_word[DATA_W-9:0], in_data};
    assign w_sum_next  = sum8(r_sum, in_data);

    assign imem_addr  = r_imem_addr;
    assign imem_data  = r_imem_data;
    assign imem_wren  = r_imem_wren;
    assign core_rst_n = r_core_rst_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

    // Next-state decode for the load sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    if (word_count == ADDR_ZERO) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next = ST_RECV;
                    end
                end else begin
                    w_next = r_state;
                end
            end
            ST_RECV: begin
                if (w_accept && (r_byte_idx == 2'd3)) begin
                    w_next = ST_WRITE;
                end else begin
                    w_next = ST_RECV;
                end
            end
            ST_WRITE: begin
                if (w_last_word) begin
                    w_next = ST_CHK;
                end else begin
                    w_next = ST_RECV;
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    if (w_sum_next == 8'd0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_ERR;
                    end
                end else begin
                    w_next = ST_CHK;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register plus load context (base, count, indices, checksum, word buffer).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_base     <= ADDR_ZERO;
            r_count    <= ADDR_ZERO;
            r_word_idx <= ADDR_ZERO;
            r_byte_idx <= 2'd0;
            r_sum      <= 8'd0;
            r_word     <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_base     <= base_addr;
                r_count    <= word_count;
                r_word_idx <= ADDR_ZERO;
                r_byte_idx <= 2'd0;
                r_sum      <= 8'd0;
                r_word     <= {DATA_W{1'b0}};
            end else if ((r_state == ST_RECV) && w_accept) begin
                r_word     <= w_word_next;
                r_sum      <= w_sum_next;
                r_byte_idx <= r_byte_idx + 2'd1;
            end else if (r_state == ST_WRITE) begin
                r_word_idx <= r_word_idx + ADDR_ONE;
            end else begin
                r_word_idx <= r_word_idx;
            end
        end
    end

    // Registered memory write port: the write beat is prepared on the
    // fourth byte so that wren is high exactly while the sequencer is in WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_addr <= ADDR_ZERO;
            r_imem_data <= {DATA_W{1'b0}};
            r_imem_wren <= 1'b0;
        end else begin
            if ((r_state == ST_RECV) && (w_next == ST_WRITE)) begin
                r_imem_addr <= r_base + r_word_idx;
                r_imem_data <= w_word_next;
                r_imem_wren <= 1'b1;
            end else begin
                r_imem_wren <= 1'b0;
            end
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_core_rst_n <= (w_next == ST_DONE);
            r_busy       <= (w_next == ST_RECV) | (w_next == ST_WRITE) | (w_next == ST_CHK);
            r_done       <= (w_next == ST_DONE);
            r_error      <= (w_next == ST_ERR);
        end
    end

endmodule
